// File: rtl/modport_fifo_pkg.sv
// modport_fifo_pkg: shared defaults, word type and address-width helper for modport_fifo
package modport_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    typedef logic [DATA_WIDTH_DEF-1:0] fifo_word_t;
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/modport_fifo_mem.sv
// modport_fifo_mem: DEPTH x DATA_WIDTH register array, sync write port, registered read port
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       re,
    input  logic [addr_w(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clock)
        if (we) mem[wr_addr] <= wr_data;
    always_ff @(posedge clock)
        if (!rst_n) rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with registered full/empty flags.
// Defining MODPORT_FIFO_COUNT_EN adds a count output exposing live occupancy.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   write,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   full,
`ifdef MODPORT_FIFO_COUNT_EN
    output logic                   empty,
    output logic [addr_w(DEPTH):0] count
`else
    output logic                   empty
`endif
);
    localparam int AW = addr_w(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
`ifndef MODPORT_FIFO_COUNT_EN
    logic [AW:0] count;
`endif
    logic [AW:0] count_nxt;
    logic wr_ok, rd_ok;
    always_comb begin
        wr_ok = write && !full;
        rd_ok = read && !empty;
        count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
    // Flags are registered from count_nxt so they move on the same edge as count.
    always_ff @(posedge clock)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_ok);
            rd_ptr <= rd_ptr + AW'(rd_ok);
            count <= count_nxt;
            full <= count_nxt == (AW+1)'(DEPTH);
            empty <= count_nxt == '0;
        end
    modport_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clock   (clock),
        .rst_n   (rst_n),
        .we      (rst_n && wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .re      (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );
endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: directed and randomized checks of modport_fifo against a queue model
module tb_modport_fifo;
    import modport_fifo_pkg::*;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    fifo_word_t data_in = '0;
    logic write = 1'b0;
    logic read = 1'b0;
    fifo_word_t data_out;
    logic full, empty;
`ifdef MODPORT_FIFO_COUNT_EN
    logic [4:0] count;
`endif
    int tests = 0;
    int fails = 0;
    fifo_word_t q[$];
    fifo_word_t m_dout = '0;

    always #5 clock = ~clock;

    modport_fifo dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .write    (write),
        .read     (read),
        .data_out (data_out),
        .full     (full),
`ifdef MODPORT_FIFO_COUNT_EN
        .empty    (empty),
        .count    (count)
`else
        .empty    (empty)
`endif
    );

    task automatic cyc(input logic w, input logic r, input fifo_word_t d);
        bit aw, ar;
        write = w;
        read = r;
        data_in = d;
        @(posedge clock);
        if (!rst_n) begin
            q.delete();
            m_dout = '0;
        end else begin
            aw = w && q.size() < 16;
            ar = r && q.size() > 0;
            if (ar) m_dout = q.pop_front();
            if (aw) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1, 0, 8'hEE);
        cyc(1, 0, 8'hEE);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_dout got=%h exp=00", data_out); end
        rst_n = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        tests++; if (empty !== 1'b1 || data_out !== 8'h00) begin fails++; $display("FAIL reset_nostore empty=%b dout=%h exp empty=1 dout=00", empty, data_out); end
    endtask

    task automatic test_basic();
        fifo_word_t exp[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) cyc(1, 0, exp[i]);
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL basic_notempty got=%b exp=0", empty); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            tests++; if (data_out !== exp[i]) begin fails++; $display("FAIL basic_rd%0d got=%h exp=%h", i, data_out, exp[i]); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_read_empty();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            tests++; if (data_out !== 8'h33 || empty !== 1'b1) begin fails++; $display("FAIL rdempty_%0d dout=%h empty=%b exp dout=33 empty=1", i, data_out, empty); end
        end
        cyc(1, 0, 8'h44);
        cyc(0, 1, 0);
        tests++; if (data_out !== 8'h44) begin fails++; $display("FAIL rdempty_ptr got=%h exp=44", data_out); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
        tests++; if (full !== 1'b1 || empty !== 1'b0) begin fails++; $display("FAIL full_set full=%b empty=%b exp full=1 empty=0", full, empty); end
        cyc(1, 0, 8'hAA);
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_drop full=%b exp=1", full); end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0);
            tests++; if (data_out !== 8'(i)) begin fails++; $display("FAIL full_rd%0d got=%h exp=%h", i, data_out, 8'(i)); end
        end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL full_drain empty=%b full=%b exp empty=1 full=0", empty, full); end
        cyc(0, 1, 0);
        tests++; if (data_out === 8'hAA) begin fails++; $display("FAIL full_noaa got=%h exp=0f", data_out); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'h80 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 8'h88 + 8'(i));
            tests++; if (data_out !== 8'h80 + 8'(i) || full !== 1'b0 || empty !== 1'b0) begin fails++; $display("FAIL b2b_%0d dout=%h full=%b empty=%b exp dout=%h full=0 empty=0", i, data_out, full, empty, 8'h80 + 8'(i)); end
`ifdef MODPORT_FIFO_COUNT_EN
            tests++; if (count !== 5'd8) begin fails++; $display("FAIL b2b_count%0d got=%0d exp=8", i, count); end
`endif
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0);
            tests++; if (data_out !== 8'h94 + 8'(i)) begin fails++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, data_out, 8'h94 + 8'(i)); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'hC0 + 8'(i));
        rst_n = 1'b0;
        cyc(1, 1, 8'hDD);
        rst_n = 1'b1;
        tests++; if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin fails++; $display("FAIL rstmid empty=%b full=%b dout=%h exp empty=1 full=0 dout=00", empty, full, data_out); end
        cyc(1, 0, 8'h5A);
        cyc(0, 1, 0);
        tests++; if (data_out !== 8'h5A || empty !== 1'b1) begin fails++; $display("FAIL rstmid_rd dout=%h empty=%b exp dout=5a empty=1", data_out, empty); end
    endtask

    task automatic test_random();
        int wp;
        for (int i = 0; i < 600; i++) begin
            wp = ((i / 60) % 2 == 0) ? 75 : 25;
            rst_n = ($urandom_range(199) != 0);
            cyc($urandom_range(99) < wp, $urandom_range(99) >= wp - 25, 8'($urandom));
            rst_n = 1'b1;
            tests++;
            if ({data_out, full, empty} !== {m_dout, q.size() == 16, q.size() == 0}) begin
                fails++;
                $display("FAIL rand_%0d dout=%h full=%b empty=%b exp dout=%h full=%b empty=%b", i, data_out, full, empty, m_dout, q.size() == 16, q.size() == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_empty();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
